// File: rtl/goldschmidt_control.sv
// Sequencing FSM for the Goldschmidt divider datapath: initial D/N scaling, then N-before-D refinement iterations.
// Optional abort input enabled by defining GOLDSCHMIDT_CONTROL_ABORT_EN.
module goldschmidt_control #(
  parameter int ITER_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef GOLDSCHMIDT_CONTROL_ABORT_EN
  input  logic              abort,
`endif
  input  logic [ITER_W-1:0] iters,
  output logic              kSelect,
  output logic [1:0]        ndSelect,
  output logic              nEnable,
  output logic              dEnable,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT_D = 3'd1,
    INIT_N = 3'd2,
    ITER_N = 3'd3,
    ITER_D = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ITER_W-1:0] iters_q;
  logic [ITER_W-1:0] count_q;
  logic [ITER_W:0]   count_inc;
  logic              more_iters;
  logic              in_busy_state;
  logic              abort_hit;

  // Compare one bit wider so iters of all-ones never wraps the comparison.
  assign count_inc  = {1'b0, count_q} + {{ITER_W{1'b0}}, 1'b1};
  assign more_iters = count_inc < {1'b0, iters_q};

  assign in_busy_state = (state == INIT_D) || (state == INIT_N) ||
                         (state == ITER_N) || (state == ITER_D);

`ifdef GOLDSCHMIDT_CONTROL_ABORT_EN
  assign abort_hit = abort && in_busy_state;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      iters_q <= '0;
      count_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        iters_q <= iters;
        count_q <= '0;
      end else if (state == ITER_D && !abort_hit) begin
        count_q <= count_q + {{(ITER_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    state_next = state;
    if (abort_hit) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = INIT_D;
        INIT_D:  state_next = INIT_N;
        INIT_N:  state_next = (iters_q != '0) ? ITER_N : DONE;
        ITER_N:  state_next = ITER_D;
        ITER_D:  state_next = more_iters ? ITER_N : DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Moore decode: N is always written before D so k tracks the current newD.
  always_comb begin
    kSelect  = 1'b0;
    ndSelect = 2'b00;
    nEnable  = 1'b0;
    dEnable  = 1'b0;
    busy     = in_busy_state;
    done     = 1'b0;
    case (state)
      INIT_D: begin
        ndSelect = 2'b00;
        dEnable  = 1'b1;
      end
      INIT_N: begin
        ndSelect = 2'b01;
        nEnable  = 1'b1;
      end
      ITER_N: begin
        kSelect  = 1'b1;
        ndSelect = 2'b11;
        nEnable  = 1'b1;
      end
      ITER_D: begin
        kSelect  = 1'b1;
        ndSelect = 2'b10;
        dEnable  = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign iter_count = count_q;

endmodule
